pipe_stage_reg: RTL

Generic parametrised pipeline-stage register with a valid/ready handshake on both sides, replacing the hand-written per-stage registers between IF/ID/EX/MEM/WB. It carries an opaque payload (the concatenated control and data fields of a stage) and supports optional skid buffering to cut the combinational ready path. It also supports a synchronous flush for branch or exception squash and a transfer counter for performance bring-up. One instance sits between each pair of adjacent pipeline stages.

---
 rtl/pipe_stage_reg.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake on both sides.
// SKID=0: one entry, in_ready combinationally follows out_ready.
// SKID=1: two entries (main + skid), in_ready decoded from registered state,
//         so no combinational path crosses the stage.
// flush squashes held entries and drops the offered payload; an output
// transfer in the same cycle still counts. xfer_count wraps naturally.
module pipe_stage_reg #(
    parameter int unsigned          PAYLOAD_W     = 64,
    parameter int unsigned          SKID          = 1,
    parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = '0,
    parameter int unsigned          CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    logic                 in_fire;
    logic                 out_fire;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign in_fire     = in_valid & in_ready & ~flush;
    assign out_fire    = out_valid & out_ready;
    assign out_payload = main_q;
    assign xfer_count  = cnt_q;

    // Transfer counter: one step per completed output transfer, flush or not.
    always_comb begin
        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and main payload registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            main_q <= RESET_PAYLOAD;
        end else begin
            cnt_q  <= cnt_d;
            main_q <= main_d;
        end
    end

    generate
        if (SKID == 0) begin : g_single
            logic full_q, full_d;

            assign in_ready  = ~full_q | out_ready;
            assign out_valid = full_q;
            assign occupancy = {1'b0, full_q};

            // Single-entry next state: flush empties, a fill wins over a drain.
            always_comb begin
                full_d = full_q;
                main_d = main_q;
                if (flush) begin
                    full_d = 1'b0;
                end else if (in_fire) begin
                    full_d = 1'b1;
                    main_d = in_payload;
                end else if (out_fire) begin
                    full_d = 1'b0;
                end
            end

            // Occupancy flag register.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    full_q <= 1'b0;
                end else begin
                    full_q <= full_d;
                end
            end
        end else begin : g_skid
            state_e               state_q, state_d;
            logic [PAYLOAD_W-1:0] skid_q, skid_d;

            assign in_ready  = (state_q != ST_TWO);
            assign out_valid = (state_q != ST_EMPTY);

            // Entry count decoded from the state.
            always_comb begin
                occupancy = 2'd0;
                case (state_q)
                    ST_ONE:  occupancy = 2'd1;
                    ST_TWO:  occupancy = 2'd2;
                    default: occupancy = 2'd0;
                endcase
            end

            // Two-entry next state; main always holds the oldest entry.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_d = ST_ONE;
                                main_d  = in_payload;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                main_d = in_payload;
                            end else if (in_fire) begin
                                state_d = ST_TWO;
                                skid_d  = in_payload;
                            end else if (out_fire) begin
                                state_d = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (out_fire) begin
                                state_d = ST_ONE;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                end
            end

            // State and skid payload registers.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    state_q <= ST_EMPTY;
                    skid_q  <= RESET_PAYLOAD;
                end else begin
                    state_q <= state_d;
                    skid_q  <= skid_d;
                end
            end
        end
    endgenerate

endmodule
